lv_lbist_seq: RTL and testbench

//  Parametrised LV logic-BIST sequencer; successor to the single-pass LV BIST controller.

---
 rtl/lv_lbist_seq.sv | 187 ++++++++++++++++++
 tb/tb_lv_lbist_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lv_lbist_seq.sv
// LV logic-BIST sequencer: runs CH_NUM request/ack self-test channels one
// after another, REQ_NUM requests each with a per-request ack timeout, watches
// MON_NUM fault-pulse inputs during the run and reports per-channel, monitor
// and global pass/fail plus a global-timeout flag.
//
// Request/ack handshake: o_ch_req[ch] is a registered level that stays high
// for the whole WAIT phase of the active channel. The client answers with a
// single-cycle i_ch_ack[ch] pulse; i_ch_err[ch] is only looked at in the cycle
// that ack is sampled high. The request drops on the edge that takes the ack,
// then stays low for exactly one GAP cycle before the next request rises.
// Acks/errs from inactive channels or outside WAIT are ignored.
module lv_lbist_seq #(
  parameter int CH_NUM   = 2,
  parameter int REQ_NUM  = 4,
  parameter int PASS_NUM = 3,
  parameter int MON_NUM  = 2,
  parameter int ACK_TMO  = 96,
  parameter int GLB_TMO  = 96000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_bist_en,
  output logic [CH_NUM-1:0]  o_ch_req,
  input  logic [CH_NUM-1:0]  i_ch_ack,
  input  logic [CH_NUM-1:0]  i_ch_err,
  input  logic [MON_NUM-1:0] i_mon_pulse,
  output logic [CH_NUM-1:0]  o_ch_pass,
  output logic               o_mon_pass,
  output logic               o_bist_tmo,
  output logic               o_bist_pass,
  output logic               o_bist_done,
  output logic [1:0]         o_dbg_state
);

  localparam int CW = $clog2(CH_NUM + 1);
  localparam int RW = $clog2(REQ_NUM + 1);
  localparam int AW = $clog2(ACK_TMO + 1);
  localparam int GW = $clog2(GLB_TMO + 1);

  localparam logic [RW-1:0] REQ_MAX  = RW'(REQ_NUM);
  localparam logic [RW-1:0] PASS_MIN = RW'(PASS_NUM);
  localparam logic [AW-1:0] ACK_MAX  = AW'(ACK_TMO);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TMO - 1);
  localparam logic [GW-1:0] GLB_MAX  = GW'(GLB_TMO);
  localparam logic [GW-1:0] GLB_LAST = GW'(GLB_TMO - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(CH_NUM - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  if (PASS_NUM > REQ_NUM) begin : g_bad_pass_num
    $error("lv_lbist_seq: PASS_NUM must not exceed REQ_NUM");
  end

  logic [1:0]        state;
  logic [CW-1:0]     ch;
  logic [RW-1:0]     req_cnt;
  logic [RW-1:0]     ok_cnt;
  logic [AW-1:0]     ack_cnt;
  logic [GW-1:0]     glb_cnt;
  logic              mon_seen;
  logic [CH_NUM-1:0] ch_pass_r;
  logic              mon_pass_r;
  logic              tmo_r;
  logic              done_r;
  logic [CH_NUM-1:0] ch_req_r;

  logic [CH_NUM-1:0] ch_mask;
  logic              ack_hit;
  logic              err_hit;
  logic              ack_exp;
  logic              glb_exp;
  logic              mon_now;
  logic              last_ch;

  // Decode the active channel and the per-cycle events the FSM reacts to.
  always_comb begin
    ch_mask = CH_NUM'(1) << ch;
    ack_hit = (state == S_WAIT) && ((i_ch_ack & ch_mask) != '0);
    err_hit = (i_ch_err & ch_mask) != '0;
    ack_exp = ack_cnt >= ACK_LAST;
    glb_exp = ((state == S_WAIT) || (state == S_GAP)) && (glb_cnt >= GLB_LAST);
    mon_now = mon_seen | (|i_mon_pulse);
    last_ch = ch >= CH_LAST;
  end

  // Sequencer FSM, counters and result registers; disable aborts everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      ch         <= '0;
      req_cnt    <= '0;
      ok_cnt     <= '0;
      ack_cnt    <= '0;
      glb_cnt    <= '0;
      mon_seen   <= 1'b0;
      ch_pass_r  <= '0;
      mon_pass_r <= 1'b0;
      tmo_r      <= 1'b0;
      done_r     <= 1'b0;
      ch_req_r   <= '0;
    end else if (!i_bist_en) begin
      state      <= S_IDLE;
      ch         <= '0;
      req_cnt    <= '0;
      ok_cnt     <= '0;
      ack_cnt    <= '0;
      glb_cnt    <= '0;
      mon_seen   <= 1'b0;
      ch_pass_r  <= '0;
      mon_pass_r <= 1'b0;
      tmo_r      <= 1'b0;
      done_r     <= 1'b0;
      ch_req_r   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state     <= S_WAIT;
          ch        <= '0;
          req_cnt   <= '0;
          ok_cnt    <= '0;
          ack_cnt   <= '0;
          glb_cnt   <= '0;
          mon_seen  <= 1'b0;
          ch_pass_r <= '0;
          ch_req_r  <= CH_NUM'(1);
        end
        S_WAIT, S_GAP: begin
          if (glb_cnt != GLB_MAX) glb_cnt <= glb_cnt + GW'(1);
          mon_seen <= mon_now;
          if (glb_exp) begin
            // Global timeout beats any same-cycle ack or channel step;
            // unfinished channels keep their cleared pass bit.
            state      <= S_DONE;
            tmo_r      <= 1'b1;
            done_r     <= 1'b1;
            mon_pass_r <= ~mon_now;
            ch_req_r   <= '0;
          end else if (state == S_WAIT) begin
            if (ack_hit || ack_exp) begin
              // An ack arriving on the timeout cycle still counts as an ack.
              state    <= S_GAP;
              ch_req_r <= '0;
              ack_cnt  <= '0;
              if (req_cnt != REQ_MAX) req_cnt <= req_cnt + RW'(1);
              if (ack_hit && !err_hit && (ok_cnt != REQ_MAX)) ok_cnt <= ok_cnt + RW'(1);
            end else if (ack_cnt != ACK_MAX) begin
              ack_cnt <= ack_cnt + AW'(1);
            end
          end else begin
            if (req_cnt < REQ_MAX) begin
              state    <= S_WAIT;
              ch_req_r <= ch_mask;
            end else begin
              ch_pass_r <= ch_pass_r | ((ok_cnt >= PASS_MIN) ? ch_mask : '0);
              req_cnt   <= '0;
              ok_cnt    <= '0;
              if (last_ch) begin
                state      <= S_DONE;
                done_r     <= 1'b1;
                mon_pass_r <= ~mon_now;
              end else begin
                state    <= S_WAIT;
                ch       <= ch + CW'(1);
                ch_req_r <= ch_mask << 1;
              end
            end
          end
        end
        default: begin
          // DONE: results frozen until the enable drops.
        end
      endcase
    end
  end

  assign o_ch_req    = ch_req_r;
  assign o_ch_pass   = done_r ? ch_pass_r : '0;
  assign o_mon_pass  = done_r & mon_pass_r;
  assign o_bist_tmo  = done_r & tmo_r;
  assign o_bist_pass = done_r & (&ch_pass_r) & mon_pass_r & ~tmo_r;
  assign o_bist_done = done_r;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_lv_lbist_seq.sv
// Bench for lv_lbist_seq: two instances (global timeout 400 and 40) driven by
// the same scenarios; a client responder answers each instance's requests and
// a timeline model predicts results, run length and request activity.
module tb_lv_lbist_seq;

  localparam int ACKT = 16;
  localparam int GA   = 400;
  localparam int GB   = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mon = 2'b00;

  logic [1:0] req_a, ack_a, err_a, pass_a, st_a;
  logic       mp_a, tmo_a, bp_a, done_a;
  logic [1:0] req_b, ack_b, err_b, pass_b, st_b;
  logic       mp_b, tmo_b, bp_b, done_b;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  lv_lbist_seq #(.CH_NUM(2), .REQ_NUM(4), .PASS_NUM(3), .MON_NUM(2),
                 .ACK_TMO(ACKT), .GLB_TMO(GA)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_bist_en(en), .o_ch_req(req_a),
    .i_ch_ack(ack_a), .i_ch_err(err_a), .i_mon_pulse(mon), .o_ch_pass(pass_a),
    .o_mon_pass(mp_a), .o_bist_tmo(tmo_a), .o_bist_pass(bp_a),
    .o_bist_done(done_a), .o_dbg_state(st_a));

  lv_lbist_seq #(.CH_NUM(2), .REQ_NUM(4), .PASS_NUM(3), .MON_NUM(2),
                 .ACK_TMO(ACKT), .GLB_TMO(GB)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_bist_en(en), .o_ch_req(req_b),
    .i_ch_ack(ack_b), .i_ch_err(err_b), .i_mon_pulse(mon), .o_ch_pass(pass_b),
    .o_mon_pass(mp_b), .o_bist_tmo(tmo_b), .o_bist_pass(bp_b),
    .o_bist_done(done_b), .o_dbg_state(st_b));

  logic [1:0] req_v  [2];
  logic [1:0] pass_v [2];
  logic       done_v [2];
  logic       mp_v   [2];
  logic       tmo_v  [2];
  logic       bp_v   [2];
  assign req_v[0] = req_a;   assign req_v[1] = req_b;
  assign pass_v[0] = pass_a; assign pass_v[1] = pass_b;
  assign done_v[0] = done_a; assign done_v[1] = done_b;
  assign mp_v[0] = mp_a;     assign mp_v[1] = mp_b;
  assign tmo_v[0] = tmo_a;   assign tmo_v[1] = tmo_b;
  assign bp_v[0] = bp_a;     assign bp_v[1] = bp_b;

  // ---------------- scenario records ----------------
  // dly = cycles from request rise to ack (0 = never ack)
  typedef struct packed {
    logic [1:0][3:0][4:0] dly;
    logic [1:0][3:0]      err;
    logic [7:0]           mon_rel;
    logic [1:0]           mon_bit;
    logic [7:0]           spur_rel;
  } scen_t;

  typedef struct packed {
    scen_t      sc;
    logic [1:0] ea_pass;
    logic       ea_mon;
    logic       ea_tmo;
    logic [8:0] ea_t;
    logic [1:0] eb_pass;
    logic       eb_tmo;
  } vec_t;

  scen_t sc;
  int    rsp_hc  [2][2];
  int    rsp_idx [2][2];
  int    hi_o    [2][2];
  int    np_o    [2][2];
  int    t_o     [2];
  logic  bad_o   [2];
  logic [1:0] prev_req [2];

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Timeline model: each request occupies min(delay, ACK_TMO) WAIT cycles
  // (never-acked = ACK_TMO) plus one GAP cycle; the run is cut at glb cycles.
  task automatic model(input scen_t s, input int glb, output int t,
                       output logic [1:0] cp, output logic tm, output logic mp,
                       output int h0, output int h1, output int p0, output int p1);
    int cum, ok, w, d, h;
    logic acked;
    cum = 0; cp = 2'b00; h0 = 0; h1 = 0; p0 = 0; p1 = 0;
    for (int c = 0; c < 2; c++) begin
      ok = 0;
      for (int r = 0; r < 4; r++) begin
        d = int'(s.dly[c][r]);
        acked = (d != 0) && (d <= ACKT);
        w = acked ? d : ACKT;
        if (cum < glb) begin
          h = ((cum + w < glb) ? cum + w : glb) - cum;
          if (c == 0) begin h0 += h; p0++; end
          else        begin h1 += h; p1++; end
        end
        cum += w + 1;
        if (acked && !s.err[c][r]) ok++;
      end
      if (cum < glb && ok >= 3) cp[c] = 1'b1;
    end
    tm = (cum >= glb);
    t  = tm ? glb : cum;
    mp = !((s.mon_rel != 0) && (int'(s.mon_rel) <= t) && (s.mon_bit != 0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_tracking();
    for (int x = 0; x < 2; x++) begin
      t_o[x] = -1; bad_o[x] = 1'b0; prev_req[x] = 2'b00;
      for (int c = 0; c < 2; c++) begin
        rsp_hc[x][c] = 0; rsp_idx[x][c] = 0; hi_o[x][c] = 0; np_o[x][c] = 0;
      end
    end
  endtask

  // Client responder plus monitor / spurious-ack injection for cycle rel.
  task automatic drive(input int rel);
    logic [1:0] ak [2];
    logic [1:0] er [2];
    int cur, d;
    for (int x = 0; x < 2; x++) begin
      ak[x] = 2'b00; er[x] = 2'b00;
      for (int c = 0; c < 2; c++) begin
        if (req_v[x][c]) begin
          rsp_hc[x][c]++;
          if (rsp_hc[x][c] == 1) rsp_idx[x][c]++;
          cur = rsp_idx[x][c] - 1;
          if (cur > 3) cur = 3;
          d = int'(sc.dly[c][cur]);
          if (d != 0 && rsp_hc[x][c] == d) begin
            ak[x][c] = 1'b1;
            er[x][c] = sc.err[c][cur];
          end
        end else begin
          rsp_hc[x][c] = 0;
        end
      end
      if (rel == int'(sc.spur_rel)) begin
        ak[x][1] = 1'b1; er[x][1] = 1'b1;
      end
    end
    ack_a = ak[0]; err_a = er[0];
    ack_b = ak[1]; err_b = er[1];
    mon = (rel == int'(sc.mon_rel)) ? sc.mon_bit : 2'b00;
  endtask

  task automatic observe(input int rel);
    for (int x = 0; x < 2; x++) begin
      for (int c = 0; c < 2; c++) begin
        if (req_v[x][c]) hi_o[x][c]++;
        if (req_v[x][c] && !prev_req[x][c]) np_o[x][c]++;
      end
      prev_req[x] = req_v[x];
      if (!done_v[x] && (pass_v[x] != 2'b00 || mp_v[x] || tmo_v[x] || bp_v[x])) bad_o[x] = 1'b1;
      if ($countones(req_v[x]) > 1) bad_o[x] = 1'b1;
      if (done_v[x]) begin
        if (t_o[x] < 0) t_o[x] = rel - 1;
        if (req_v[x] != 2'b00) bad_o[x] = 1'b1;
      end else if (t_o[x] >= 0) begin
        bad_o[x] = 1'b1;
      end
    end
  endtask

  task automatic quiesce();
    en = 1'b0; ack_a = 2'b00; err_a = 2'b00; ack_b = 2'b00; err_b = 2'b00; mon = 2'b00;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input logic use_exp, input string tag);
    int t, h0, h1, p0, p1;
    logic [1:0] cp;
    logic tm, mp, fin;
    string dn;
    sc = v.sc;
    clear_tracking();
    fin = 1'b0;
    @(negedge clk);
    en = 1'b1;
    for (int rel = 1; rel <= 700; rel++) begin
      @(negedge clk);
      observe(rel);
      if (done_v[0] && done_v[1] && rel > int'(sc.mon_rel) + 1) begin
        fin = 1'b1;
        break;
      end
      drive(rel);
    end
    chk({tag, "_finished"}, int'(fin), 1);
    for (int x = 0; x < 2; x++) begin
      model(v.sc, (x == 0) ? GA : GB, t, cp, tm, mp, h0, h1, p0, p1);
      if (use_exp) begin
        if (x == 0) begin
          t = int'(v.ea_t); cp = v.ea_pass; tm = v.ea_tmo; mp = v.ea_mon;
        end else begin
          cp = v.eb_pass; tm = v.eb_tmo;
        end
      end
      dn = (x == 0) ? "_a" : "_b";
      chk({tag, dn, "_done_cycle"}, t_o[x], t);
      chk({tag, dn, "_ch_pass"},   int'(pass_v[x]), int'(cp));
      chk({tag, dn, "_mon_pass"},  int'(mp_v[x]), int'(mp));
      chk({tag, dn, "_tmo"},       int'(tmo_v[x]), int'(tm));
      chk({tag, dn, "_bist_pass"}, int'(bp_v[x]), int'((&cp) & mp & ~tm));
      chk({tag, dn, "_req0_hi"},   hi_o[x][0], h0);
      chk({tag, dn, "_req1_hi"},   hi_o[x][1], h1);
      chk({tag, dn, "_req0_cnt"},  np_o[x][0], p0);
      chk({tag, dn, "_req1_cnt"},  np_o[x][1], p1);
      chk({tag, dn, "_protocol"},  int'(bad_o[x]), 0);
    end
    quiesce();
  endtask

  function automatic vec_t mk(input int d0, input int d1, input logic [3:0] e0,
                              input logic [3:0] e1, input int mr, input logic [1:0] mb,
                              input int sp, input logic [1:0] ap, input logic am,
                              input logic at, input int att, input logic [1:0] bpp,
                              input logic bt);
    vec_t v;
    for (int r = 0; r < 4; r++) begin
      v.sc.dly[0][r] = 5'(d0);
      v.sc.dly[1][r] = 5'(d1);
    end
    v.sc.err[0] = e0; v.sc.err[1] = e1;
    v.sc.mon_rel = 8'(mr); v.sc.mon_bit = mb; v.sc.spur_rel = 8'(sp);
    v.ea_pass = ap; v.ea_mon = am; v.ea_tmo = at; v.ea_t = 9'(att);
    v.eb_pass = bpp; v.eb_tmo = bt;
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs [11];
    vec_t rv;
    logic found;

    ack_a = 2'b00; err_a = 2'b00; ack_b = 2'b00; err_b = 2'b00;

    //            d0  d1  err0     err1     mr  mb     sp  a_pass a_mon a_tmo a_t b_pass b_tmo
    vecs[0]  = mk( 3,  3, 4'b0000, 4'b0000,  0, 2'b00, 0, 2'b11, 1'b1, 1'b0, 32, 2'b11, 1'b0);
    vecs[1]  = mk( 3,  3, 4'b0000, 4'b0110,  0, 2'b00, 0, 2'b01, 1'b1, 1'b0, 32, 2'b01, 1'b0);
    vecs[2]  = mk( 3,  3, 4'b0000, 4'b0010,  0, 2'b00, 0, 2'b11, 1'b1, 1'b0, 32, 2'b11, 1'b0);
    vecs[3]  = mk( 0,  3, 4'b0000, 4'b0000,  0, 2'b00, 0, 2'b10, 1'b1, 1'b0, 84, 2'b00, 1'b1);
    vecs[4]  = mk( 3,  3, 4'b0000, 4'b0000,  2, 2'b10, 0, 2'b11, 1'b0, 1'b0, 32, 2'b11, 1'b0);
    vecs[5]  = mk( 3,  3, 4'b0000, 4'b0000, 40, 2'b10, 0, 2'b11, 1'b1, 1'b0, 32, 2'b11, 1'b0);
    vecs[6]  = mk( 3,  3, 4'b0000, 4'b0000,  0, 2'b00, 2, 2'b11, 1'b1, 1'b0, 32, 2'b11, 1'b0);
    vecs[7]  = mk(16,  3, 4'b0000, 4'b0000,  0, 2'b00, 0, 2'b11, 1'b1, 1'b0, 84, 2'b00, 1'b1);
    vecs[8]  = mk(17,  3, 4'b0000, 4'b0000,  0, 2'b00, 0, 2'b10, 1'b1, 1'b0, 84, 2'b00, 1'b1);
    vecs[9]  = mk( 1,  1, 4'b0000, 4'b0000,  0, 2'b00, 0, 2'b11, 1'b1, 1'b0, 16, 2'b11, 1'b0);
    vecs[10] = mk( 3,  3, 4'b0001, 4'b1111,  0, 2'b00, 0, 2'b01, 1'b1, 1'b0, 32, 2'b01, 1'b0);

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_req",       int'(req_a),  0);
    chk("reset_done",      int'(done_a), 0);
    chk("reset_ch_pass",   int'(pass_a), 0);
    chk("reset_mon_pass",  int'(mp_a),   0);
    chk("reset_tmo",       int'(tmo_a),  0);
    chk("reset_bist_pass", int'(bp_a),   0);
    chk("reset_state",     int'(st_a),   0);
    chk("reset_b_req",     int'(req_b),  0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_req",  int'(req_a), 0);
    chk("idle_done", int'(done_a), 0);

    // table-driven vectors
    for (int i = 0; i < 11; i++) run_vec(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // abort mid-WAIT on ch1, then restart
    sc = vecs[0].sc;
    clear_tracking();
    found = 1'b0;
    @(negedge clk);
    en = 1'b1;
    for (int rel = 1; rel <= 200; rel++) begin
      @(negedge clk);
      if (req_a[1]) begin found = 1'b1; break; end
      drive(rel);
    end
    chk("abort_reach_ch1", int'(found), 1);
    en = 1'b0; ack_a = 2'b00; err_a = 2'b00; ack_b = 2'b00; err_b = 2'b00; mon = 2'b00;
    @(negedge clk);
    chk("abort_req",       int'(req_a),  0);
    chk("abort_done",      int'(done_a), 0);
    chk("abort_ch_pass",   int'(pass_a), 0);
    chk("abort_bist_pass", int'(bp_a),   0);
    chk("abort_tmo",       int'(tmo_a),  0);
    chk("abort_state",     int'(st_a),   0);
    en = 1'b1;
    @(negedge clk);
    chk("reenable_req", int'(req_a), 1);
    quiesce();

    // randomized scenarios against the model
    for (int n = 0; n < 24; n++) begin
      rv = '0;
      for (int c = 0; c < 2; c++) begin
        for (int r = 0; r < 4; r++) begin
          rv.sc.dly[c][r] = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 18));
          rv.sc.err[c][r] = ($urandom_range(0, 3) == 0);
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        rv.sc.mon_rel = 8'($urandom_range(1, 150));
        rv.sc.mon_bit = 2'($urandom_range(1, 3));
      end
      run_vec(rv, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
